// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot program loader.
interface program_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_write_en;
    logic [31:0] imem_address;
    logic [31:0] imem_write_data;

    // master: byte source and memory sink; slave: the loader itself
    modport master (
        output rx_data, rx_valid,
        input  rx_ready, imem_write_en, imem_address, imem_write_data
    );
    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, imem_write_en, imem_address, imem_write_data
    );
endinterface

// File: rtl/program_loader.sv
// Boot program loader: little-endian word-count + payload byte stream into imem writes.
// Optional trailing XOR checksum byte enabled by PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    program_loader_if.slave   bus,
    output logic              core_reset,
    output logic              done,
    output logic              error
);
    localparam int          IDX_W   = $clog2(DEPTH) + 1;
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    typedef enum logic [2:0] {
        S_COUNT,
        S_DATA,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERROR
    } state_t;

    // State reached once the payload (or an empty count) is complete
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam state_t S_TAIL = S_CSUM;
`else
    localparam state_t S_TAIL = S_DONE;
`endif

    state_t           state, state_nxt;
    logic [1:0]       byte_cnt;
    logic [23:0]      shift;
    logic [31:0]      count;
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             word_end;
    logic             last_word;
    logic [31:0]      word_full;
    logic             loading_nxt;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]       csum;
`endif

    assign accept    = bus.rx_valid && bus.rx_ready;
    assign word_full = {bus.rx_data, shift};
    assign word_end  = accept && (byte_cnt == 2'd3);
    assign last_word = (32'(idx) + 32'd1) == count;

    always_ff @(posedge clk) begin
        if (reset) state <= S_COUNT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_COUNT: begin
                if (word_end) begin
                    if (word_full > DEPTH_W)   state_nxt = S_ERROR;
                    else if (word_full == '0)  state_nxt = S_TAIL;
                    else                       state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (word_end && last_word) state_nxt = S_TAIL;
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept) state_nxt = (bus.rx_data == csum) ? S_DONE : S_ERROR;
            end
`endif
            default: state_nxt = state;
        endcase
    end

    assign loading_nxt = (state_nxt != S_DONE) && (state_nxt != S_ERROR);

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt            <= 2'd0;
            shift               <= '0;
            count               <= '0;
            idx                 <= '0;
            bus.rx_ready        <= 1'b0;
            bus.imem_write_en   <= 1'b0;
            bus.imem_address    <= BASE_ADDR;
            bus.imem_write_data <= '0;
            core_reset          <= 1'b1;
            done                <= 1'b0;
            error               <= 1'b0;
        end else begin
            bus.imem_write_en <= 1'b0;
            bus.rx_ready      <= loading_nxt;
            done              <= (state_nxt == S_DONE);
            error             <= (state_nxt == S_ERROR);
            core_reset        <= (state_nxt != S_DONE);

            if (accept && (state == S_COUNT || state == S_DATA)) begin
                byte_cnt <= byte_cnt + 2'd1;
                shift    <= word_full[31:8];
            end
            if (word_end && state == S_COUNT) count <= word_full;
            if (word_end && state == S_DATA) begin
                bus.imem_write_en   <= 1'b1;
                bus.imem_address    <= BASE_ADDR + (32'(idx) << 2);
                bus.imem_write_data <= word_full;
                idx                 <= idx + 1'b1;
            end
        end
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Running XOR over payload bytes only; count bytes are excluded
    always_ff @(posedge clk) begin
        if (reset)                         csum <= 8'h00;
        else if (accept && state == S_DATA) csum <= csum ^ bus.rx_data;
    end
`endif
endmodule

// File: tb/tb_program_loader.sv
// Table-driven frame tests with a write scoreboard, plus a mid-load reset sequence.
module tb_program_loader;
    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_1000;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic core_reset, done, error;

    program_loader_if bus ();

    program_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .core_reset(core_reset), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] n;
        logic [31:0] w0;
        logic [31:0] w1;
        bit          gap;
        bit          calc;
        logic [7:0]  csum;
        bit          exp_done;
    } vec_t;

    localparam int NV = 9;
    vec_t vt [NV];
    wr_t  exp_q [$];
    int   total = 0;
    int   passed = 0;
    int   n_writes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail(input string name);
        total++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    // Write scoreboard
    always @(negedge clk) begin
        if (bus.imem_write_en === 1'b1) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                fail("unexpected_write");
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", bus.imem_address, e.addr);
                check("wr_data", bus.imem_write_data, e.data);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] word_of(input int v, input int i);
        if (i == 0) return vt[v].w0;
        if (i == 1) return vt[v].w1;
        return 32'h9E37_79B9 * 32'(i + v);
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t;
        t = 0;
        while (bus.rx_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (bus.rx_ready !== 1'b1) begin
            fail("rx_ready_timeout");
            return;
        end
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        if (gap) @(negedge clk);
    endtask

    task automatic do_reset();
        bus.rx_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        exp_q.delete();
        n_writes = 0;
    endtask

    logic [7:0]  bq [$];
    int          wq [$];
    logic [7:0]  x;
    logic [31:0] w;
    int          nw;
    bit          ok;

    initial begin
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;

        //          n              w0            w1            gap   calc  csum   exp_done
        vt[0] = '{32'd2,          32'h00500093, 32'h00A00113, 1'b0, 1'b1, 8'h00, 1'b1};
        vt[1] = '{32'd2,          32'h00500093, 32'h00A00113, 1'b1, 1'b1, 8'h00, 1'b1};
        vt[2] = '{32'd257,        32'h0,        32'h0,        1'b0, 1'b0, 8'h00, 1'b0};
        vt[3] = '{32'd0,          32'h0,        32'h0,        1'b0, 1'b0, 8'h00, 1'b1};
        vt[4] = '{32'd1,          32'h12345678, 32'h0,        1'b0, 1'b0, 8'h08, 1'b1};
        vt[5] = '{32'd1,          32'h12345678, 32'h0,        1'b1, 1'b0, 8'h09, !CK};
        vt[6] = '{32'd256,        32'hCAFEF00D, 32'h0BADC0DE, 1'b0, 1'b1, 8'h00, 1'b1};
        vt[7] = '{32'h0001_0100,  32'h0,        32'h0,        1'b0, 1'b0, 8'h00, 1'b0};
        vt[8] = '{32'h8000_0000,  32'h0,        32'h0,        1'b1, 1'b0, 8'h00, 1'b0};

        // Reset values in the cycle reset is sampled and the one after
        @(negedge clk);
        check("rst_rx_ready", bus.rx_ready, 0);
        check("rst_wr_en", bus.imem_write_en, 0);
        check("rst_addr", bus.imem_address, BASE);
        check("rst_data", bus.imem_write_data, 0);
        check("rst_core_reset", core_reset, 1);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        @(negedge clk);
        check("rst2_rx_ready", bus.rx_ready, 0);
        check("rst2_core_reset", core_reset, 1);
        reset = 1'b0;
        @(negedge clk);
        check("rst_release_rx_ready", bus.rx_ready, 1);

        for (int v = 0; v < NV; v++) begin
            do_reset();
            bq.delete();
            wq.delete();
            x = 8'h00;
            for (int k = 0; k < 4; k++) begin
                bq.push_back(vt[v].n[8*k +: 8]);
                wq.push_back(-1);
            end
            ok = (vt[v].n <= 32'(DEPTH));
            nw = ok ? int'(vt[v].n) : 0;
            for (int i = 0; i < nw; i++) begin
                w = word_of(v, i);
                for (int k = 0; k < 4; k++) begin
                    bq.push_back(w[8*k +: 8]);
                    x = x ^ w[8*k +: 8];
                    wq.push_back(k == 3 ? i : -1);
                end
            end
            if (CK && ok) begin
                bq.push_back(vt[v].calc ? x : vt[v].csum);
                wq.push_back(-1);
            end

            for (int k = 0; k < bq.size(); k++) begin
                if (wq[k] >= 0) begin
                    wr_t e;
                    e.addr = BASE + 32'(4 * wq[k]);
                    e.data = word_of(v, wq[k]);
                    exp_q.push_back(e);
                end
                if (k == bq.size() - 1) begin
                    check($sformatf("v%0d_pre_done", v), done, 0);
                    check($sformatf("v%0d_pre_error", v), error, 0);
                    check($sformatf("v%0d_pre_core_reset", v), core_reset, 1);
                end
                send_byte(bq[k], vt[v].gap && (k != bq.size() - 1));
            end

            // Cycle right after the terminal byte
            check($sformatf("v%0d_done", v), done, vt[v].exp_done);
            check($sformatf("v%0d_error", v), error, !vt[v].exp_done);
            check($sformatf("v%0d_core_reset", v), core_reset, !vt[v].exp_done);
            check($sformatf("v%0d_rx_ready", v), bus.rx_ready, 0);

            // Offer bytes in the terminal state; none may be taken
            bus.rx_data  = 8'hA5;
            bus.rx_valid = 1'b1;
            repeat (3) @(negedge clk);
            bus.rx_valid = 1'b0;
            check($sformatf("v%0d_writes", v), n_writes, nw);
            check($sformatf("v%0d_q_empty", v), exp_q.size(), 0);
            check($sformatf("v%0d_sticky_done", v), done, vt[v].exp_done);
            check($sformatf("v%0d_sticky_error", v), error, !vt[v].exp_done);
            check($sformatf("v%0d_hold_rx_ready", v), bus.rx_ready, 0);
        end

        // Mid-load reset after 6 of 8 payload bytes, then a clean one-word frame
        do_reset();
        bq.delete();
        bq = '{8'h02, 8'h00, 8'h00, 8'h00,
               8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77};
        for (int k = 0; k < bq.size(); k++) begin
            if (k == 7) begin
                wr_t e;
                e.addr = BASE;
                e.data = 32'h1122_3344;
                exp_q.push_back(e);
            end
            send_byte(bq[k], 1'b0);
        end
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_wr_en", bus.imem_write_en, 0);
        check("mid_rst_rx_ready", bus.rx_ready, 0);
        check("mid_rst_core_reset", core_reset, 1);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_release_rx_ready", bus.rx_ready, 1);
        check("mid_rst_writes", n_writes, 1);
        check("mid_rst_q_empty", exp_q.size(), 0);

        bq.delete();
        bq = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        if (CK) bq.push_back(8'h22);
        for (int k = 0; k < bq.size(); k++) begin
            if (k == 7) begin
                wr_t e;
                e.addr = BASE;
                e.data = 32'hDEAD_BEEF;
                exp_q.push_back(e);
            end
            send_byte(bq[k], 1'b0);
        end
        check("reload_done", done, 1);
        check("reload_core_reset", core_reset, 0);
        repeat (2) @(negedge clk);
        check("reload_writes", n_writes, 2);
        check("reload_q_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/program_loader.md
# program_loader

Boot-time program loader that writes the instruction memory, the write-side counterpart of the core's read-only instruction fetch. It accepts a byte stream (from a UART receiver or test harness), assembles little-endian 32-bit words and issues one instruction-memory write per word. It holds the core in reset until the image is fully and validly loaded.

## Interface
- `DEPTH`, default 256: instruction-memory capacity in words; the maximum accepted word count.
- `BASE_ADDR`, default 32'h0000_0000: byte address of the first word written.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high; restarts the loader.
- `rx_data` input 8: incoming byte.
- `rx_valid` input 1: `rx_data` is valid this cycle.
- `rx_ready` output 1: loader accepts a byte this cycle. A byte transfers when `rx_valid && rx_ready`.
- `imem_write_en` output 1: one-cycle instruction-memory write strobe.
- `imem_address` output 32: byte address of the write, word aligned.
- `imem_write_data` output 32: word to write.
- `core_reset` output 1: reset to the core's program counter and registers. Active-high.
- `done` output 1: image loaded; sticky until `reset`.
- `error` output 1: load aborted; sticky until `reset`.

## Operation
- Frame format: a 4-byte word count N (little endian), then N words of 4 bytes each (little endian, LSB first), then an optional checksum byte (see Configuration).
- States:
  - COUNT: collect 4 count bytes. If N > DEPTH, go to ERROR. If N == 0, go to CSUM when enabled, otherwise DONE. Else go to DATA.
  - DATA: collect bytes into a shift/assembly register. On each 4th byte, issue a write and increment the word index. After the Nth word, go to CSUM when enabled, otherwise DONE.
  - CSUM: accept 1 byte. If it matches, go to DONE; otherwise go to ERROR.
  - DONE: `rx_ready=0`, `done=1`, `core_reset=0`.
  - ERROR: `rx_ready=0`, `error=1`, `core_reset=1`.
- Address of word i is `BASE_ADDR + 4*i`. The index is a counter of $clog2(DEPTH)+1 bits. The count register is the full 32 bits, and the DEPTH comparison is unsigned over 32 bits.
- Bytes arriving while `rx_valid=0` are ignored. Bytes held in DONE or ERROR are never accepted.
- Instruction memory is not cleared on reset. Words not rewritten keep their old contents.

## Timing
- Reset values (cycle in which `reset=1` is sampled and the cycle after):
  - `rx_ready=0`, `imem_write_en=0`, `imem_address=BASE_ADDR`, `imem_write_data=0`, `core_reset=1`, `done=0`, `error=0`, state COUNT.
  - `rx_ready` rises in the first cycle after `reset` is deasserted.
- All outputs are registered.
- `imem_write_en` pulses for exactly one cycle, in the cycle after the 4th byte of a word is accepted. Address and data are stable in that same cycle.
- `rx_ready` stays 1 throughout COUNT, DATA and CSUM. A byte may be accepted every cycle, and a write strobe may coincide with acceptance of the next word's first byte.
- DONE is entered in the cycle after the terminal byte is accepted:
  - With no checksum, that cycle coincides with the last write strobe.
  - `core_reset` falls and `done` rises in that cycle.
- ERROR is entered in the cycle after the offending byte (4th count byte or checksum byte). No write is ever issued for an over-size count.
- `reset` asserted mid-load aborts immediately: the partial word is discarded, no strobe is issued, and the loader returns to COUNT.

## Configuration
- Macro `PROGRAM_LOADER_CHECKSUM_EN`.
- Defined:
  - A running XOR is kept over all 4N payload bytes (count bytes excluded). It is cleared on reset.
  - CSUM state is present. A mismatch forces ERROR, and `core_reset` stays 1.
- Undefined:
  - No CSUM state and no XOR register.
  - DONE follows the last payload byte (or the count when N=0).
  - `error` is asserted only by an over-size count.

## Test plan
- N=2, words 32'h00500093 and 32'h00A00113, sent back-to-back with `rx_valid` held 1 → two strobes at addresses BASE_ADDR and BASE_ADDR+4 with exactly those data values. `done` and `core_reset` change in the cycle after the last applicable byte.
- Same image with `rx_valid` toggling every other cycle → identical writes; no byte lost or duplicated.
- N=DEPTH+1 (257) → `error=1` one cycle after the 4th count byte. Zero write strobes; `rx_ready=0`; `core_reset=1`.
- N=0 → no strobes. Without the macro, `done=1` after the count; with the macro, `done=1` after checksum byte 8'h00.
- With `PROGRAM_LOADER_CHECKSUM_EN`, N=1, word 32'h12345678, checksum 8'h08 → `done`. Checksum 8'h09 → `error`, with `core_reset` held at 1.
- `reset` pulsed after 6 of 8 payload bytes, then a full N=1 frame with 32'hDEADBEEF → exactly one strobe at BASE_ADDR with 32'hDEADBEEF, then `done`.
